// File: rtl/bitmove_cmd_seq.sv
// Command sequencer for the bit-move engine: queues move descriptors and replays
// each one as SRC/DST/LEN/CTRL register writes, then waits for done/error/timeout.
module bitmove_cmd_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [31:0]              cmdSrc,
    input  logic [31:0]              cmdDst,
    input  logic [31:0]              cmdLen,
    output logic                     sRW,
    output logic                     sSel,
    output logic [2:0]               sAddr,
    output logic [31:0]              sWdata,
    input  logic                     busy,
    input  logic                     done,
    input  logic                     errSeen,
    output logic                     cplValid,
    output logic                     cplErr,
    output logic                     cplTimeout,
    output logic [15:0]              cplCount,
    output logic                     seqBusy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_SRC, S_WR_DST, S_WR_LEN, S_WR_GO, S_WAIT, S_REPORT
    } state_t;

    state_t          state_q, state_d;

    logic [31:0]     src_mem_q [DEPTH];
    logic [31:0]     dst_mem_q [DEPTH];
    logic [31:0]     len_mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            push, pop, fifo_empty;

    logic [31:0]     dst_q, len_q;
    logic [TW-1:0]   timer_q;
    logic            timer_last;
    logic            err_q, tmo_q;
    logic [15:0]     cpl_count_q;
    logic [2:0]      s_addr_q, s_addr_d;
    logic [31:0]     s_wdata_q, s_wdata_d;

    // ---------------- descriptor FIFO ----------------
    assign fifo_empty = (level_q == '0);
    assign cmdReady   = (level_q < LW'(DEPTH));
    assign push       = cmdValid && cmdReady;
    assign pop        = (state_q == S_IDLE) && (state_d == S_WR_SRC);

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset: level/pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem_q[wr_ptr_q] <= cmdSrc;
            dst_mem_q[wr_ptr_q] <= cmdDst;
            len_mem_q[wr_ptr_q] <= cmdLen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign timer_last = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!fifo_empty && !busy) state_d = S_WR_SRC;
            S_WR_SRC: state_d = S_WR_DST;
            S_WR_DST: state_d = S_WR_LEN;
            S_WR_LEN: state_d = S_WR_GO;
            S_WR_GO:  state_d = S_WAIT;
            S_WAIT:   if (done || errSeen || timer_last) state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Register-port address/data are computed from the next state so they are
    // registered yet line up with the cycle in which sSel is high.
    always_comb begin
        sSel       = (state_q == S_WR_SRC) || (state_q == S_WR_DST) ||
                     (state_q == S_WR_LEN) || (state_q == S_WR_GO);
        sRW        = sSel;
        cplValid   = (state_q == S_REPORT);
        cplErr     = cplValid && err_q;
        cplTimeout = cplValid && tmo_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        unique case (state_d)
            S_WR_SRC: begin s_addr_d = 3'd0; s_wdata_d = src_mem_q[rd_ptr_q]; end
            S_WR_DST: begin s_addr_d = 3'd1; s_wdata_d = dst_q;               end
            S_WR_LEN: begin s_addr_d = 3'd2; s_wdata_d = len_q;               end
            S_WR_GO:  begin s_addr_d = 3'd3; s_wdata_d = 32'd1;               end
            default:  ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dst_q       <= '0;
            len_q       <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            cpl_count_q <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
        end else begin
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            if (pop) begin
                dst_q <= dst_mem_q[rd_ptr_q];
                len_q <= len_mem_q[rd_ptr_q];
            end
            if (state_q == S_WR_GO)     timer_q <= '0;
            else if (state_q == S_WAIT) timer_q <= timer_q + TW'(1);
            // Error wins over timeout when both coincide.
            if (state_q == S_WAIT && state_d == S_REPORT) begin
                err_q <= errSeen;
                tmo_q <= timer_last && !done && !errSeen;
            end
            if (state_q == S_REPORT) cpl_count_q <= cpl_count_q + 16'd1;
        end
    end

    assign sAddr    = s_addr_q;
    assign sWdata   = s_wdata_q;
    assign cplCount = cpl_count_q;
    assign level    = level_q;
    assign seqBusy  = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bitmove_cmd_seq.sv
// Scoreboard bench for bitmove_cmd_seq: expected register writes and completions
// are queued at push time; a negedge monitor plays the engine and checks them.
module tb_bitmove_cmd_seq;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cmdValid = 1'b0, busy = 1'b0, done = 1'b0, errSeen = 1'b0;
    logic [31:0] cmdSrc = '0, cmdDst = '0, cmdLen = '0;
    logic        cmdReady, sRW, sSel, cplValid, cplErr, cplTimeout, seqBusy;
    logic [2:0]  sAddr;
    logic [31:0] sWdata;
    logic [15:0] cplCount;
    logic [$clog2(DEPTH):0] level;

    bitmove_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdSrc(cmdSrc), .cmdDst(cmdDst), .cmdLen(cmdLen),
        .sRW(sRW), .sSel(sSel), .sAddr(sAddr), .sWdata(sWdata),
        .busy(busy), .done(done), .errSeen(errSeen),
        .cplValid(cplValid), .cplErr(cplErr), .cplTimeout(cplTimeout),
        .cplCount(cplCount), .seqBusy(seqBusy), .level(level)
    );

    always #5 clk = ~clk;

    // mode: 0 = done after dly cycles, 1 = done+errSeen after dly, 2 = never respond
    typedef struct { logic [2:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int mode; int dly; } cpl_t;

    wr_t  exp_wr[$];
    cpl_t exp_cpl[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, ctrl_cyc = 0, last_wr_cyc = 0, exp_count = 0;
    bit   armed = 0;

    // Monitor + engine model
    always @(negedge clk) begin
        wr_t  w;
        cpl_t c;
        int   exp_cyc;
        logic exp_err, exp_tmo;
        cyc++;
        done = 1'b0;
        errSeen = 1'b0;
        if (reset) begin
            armed = 0;
            exp_count = 0;
        end else begin
            if (sSel) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", sAddr, sWdata);
                end else begin
                    w = exp_wr.pop_front();
                    if (sAddr !== w.addr || sWdata !== w.data || sRW !== 1'b1) begin
                        errors++;
                        $display("FAIL reg_write: got rw=%b addr=%0d data=%h, want rw=1 addr=%0d data=%h",
                                 sRW, sAddr, sWdata, w.addr, w.data);
                    end
                    if (w.addr != 3'd0) begin
                        checks++;
                        if (cyc != last_wr_cyc + 1) begin
                            errors++;
                            $display("FAIL write_gap: got cycle %0d, want %0d", cyc, last_wr_cyc + 1);
                        end
                    end
                    last_wr_cyc = cyc;
                    if (w.addr == 3'd3) begin
                        ctrl_cyc = cyc;
                        armed = 1;
                    end
                end
            end
            if (cplValid) begin
                checks++;
                if (exp_cpl.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cpl: got cplValid=1, none expected");
                end else begin
                    c = exp_cpl.pop_front();
                    exp_err = (c.mode == 1);
                    exp_tmo = (c.mode == 2);
                    exp_cyc = ctrl_cyc + ((c.mode == 2) ? TIMEOUT + 1 : c.dly + 1);
                    if (cplErr !== exp_err || cplTimeout !== exp_tmo ||
                        cplCount !== 16'(exp_count) || cyc != exp_cyc) begin
                        errors++;
                        $display("FAIL completion: got err=%b tmo=%b count=%0d cyc=%0d, want err=%b tmo=%b count=%0d cyc=%0d",
                                 cplErr, cplTimeout, cplCount, cyc, exp_err, exp_tmo, exp_count, exp_cyc);
                    end
                    exp_count++;
                    armed = 0;
                end
            end
            if (armed && exp_cpl.size() > 0 && exp_cpl[0].mode != 2 &&
                cyc == ctrl_cyc + exp_cpl[0].dly) begin
                done = 1'b1;
                errSeen = (exp_cpl[0].mode == 1);
            end
        end
    end

    task automatic push_cmd(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                            input int mode, input int dly);
        int n = 0;
        cmdValid = 1'b1; cmdSrc = s; cmdDst = d; cmdLen = l;
        while (!cmdReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmdReady !== 1'b1) begin
            errors++;
            $display("FAIL push_accept: got cmdReady=%b, want 1 within 200 cycles", cmdReady);
        end else begin
            exp_wr.push_back('{3'd0, s});
            exp_wr.push_back('{3'd1, d});
            exp_wr.push_back('{3'd2, l});
            exp_wr.push_back('{3'd3, 32'd1});
            exp_cpl.push_back('{mode, dly});
        end
        @(negedge clk);
        cmdValid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_cpl.size() != 0 || exp_wr.size() != 0 || seqBusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_cpl.size() != 0 || exp_wr.size() != 0 || seqBusy !== 1'b0) begin
            errors++;
            $display("FAIL drain: got pending cpl=%0d wr=%0d seqBusy=%b, want 0 0 0",
                     exp_cpl.size(), exp_wr.size(), seqBusy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cmdValid = 1'b0; busy = 1'b0;
        exp_wr.delete();
        exp_cpl.delete();
        @(negedge clk);
        checks++;
        if ({sRW, sSel, sAddr, sWdata} !== '0) begin
            errors++;
            $display("FAIL reset_sport: got rw=%b sel=%b addr=%0d data=%h, want all 0", sRW, sSel, sAddr, sWdata);
        end
        checks++;
        if ({cplValid, cplErr, cplTimeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_cpl: got %b, want 000", {cplValid, cplErr, cplTimeout});
        end
        checks++;
        if (cplCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, want 0", cplCount);
        end
        checks++;
        if (cmdReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 1", cmdReady);
        end
        checks++;
        if (seqBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_seqbusy: got %b, want 0", seqBusy);
        end
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL reset_level: got %0d, want 0", level);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        push_cmd(32'h100, 32'h2000, 32'd64, 0, 10);
        wait_drain(100);
        checks++;
        if (cplCount !== 16'd1) begin
            errors++;
            $display("FAIL single_count: got %0d, want 1", cplCount);
        end
    endtask

    task automatic test_back_to_back();
        busy = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push_cmd(32'h1000 + i, 32'h8000 + 32'(i * 16), 32'd8 + 32'(i), 0, 3);
        checks++;
        if (level !== 3'(DEPTH) || cmdReady !== 1'b0) begin
            errors++;
            $display("FAIL full: got level=%0d ready=%b, want level=%0d ready=0", level, cmdReady, DEPTH);
        end
        fork
            push_cmd(32'h1FFF, 32'h9FFF, 32'd99, 0, 3);
            begin
                repeat (4) @(negedge clk);
                checks++;
                if (level !== 3'(DEPTH)) begin
                    errors++;
                    $display("FAIL full_hold: got level=%0d, want %0d", level, DEPTH);
                end
                busy = 1'b0;
            end
        join
        wait_drain(300);
        checks++;
        if (cplCount !== 16'd6) begin
            errors++;
            $display("FAIL b2b_count: got %0d, want 6", cplCount);
        end
    endtask

    task automatic test_err();
        push_cmd(32'h300, 32'h400, 32'd0, 1, 5);
        push_cmd(32'h500, 32'h600, 32'd32, 0, 2);
        wait_drain(200);
        checks++;
        if (cplCount !== 16'd8) begin
            errors++;
            $display("FAIL err_count: got %0d, want 8", cplCount);
        end
    endtask

    task automatic test_timeout();
        push_cmd(32'hABC, 32'hDEF, 32'd7, 2, 0);
        wait_drain(100);
        checks++;
        if (cplCount !== 16'd9 || seqBusy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got count=%0d seqBusy=%b, want 9 0", cplCount, seqBusy);
        end
    endtask

    task automatic test_busy();
        int hits = 0;
        busy = 1'b1;
        push_cmd(32'h11, 32'h22, 32'd33, 0, 1);
        push_cmd(32'h44, 32'h55, 32'd66, 0, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sSel) hits++;
        end
        checks++;
        if (hits != 0 || level !== 3'd2) begin
            errors++;
            $display("FAIL busy_hold: got sel_cycles=%0d level=%0d, want 0 2", hits, level);
        end
        busy = 1'b0;
        @(negedge clk);
        checks++;
        if (sSel !== 1'b1 || sAddr !== 3'd0) begin
            errors++;
            $display("FAIL busy_release: got sel=%b addr=%0d, want 1 0", sSel, sAddr);
        end
        wait_drain(200);
        checks++;
        if (cplCount !== 16'd11) begin
            errors++;
            $display("FAIL busy_count: got %0d, want 11", cplCount);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            push_cmd(32'h700 + 32'(i), 32'h800, 32'd5, 2, 0);
        repeat (8) @(negedge clk);
        checks++;
        if (level !== 3'd2 || sSel !== 1'b0 || seqBusy !== 1'b1) begin
            errors++;
            $display("FAIL mid_state: got level=%0d sel=%b seqBusy=%b, want 2 0 1", level, sSel, seqBusy);
        end
        do_reset();
        repeat (30) @(negedge clk);
        checks++;
        if (level !== '0 || cplCount !== 16'd0 || seqBusy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: got level=%0d count=%0d seqBusy=%b, want 0 0 0", level, cplCount, seqBusy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_err();
        test_timeout();
        test_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
